if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//   Instruction-fetch stage directly downstream of the PC register. Takes the
//   current pc/ce and reads 4 bytes over the byte-wide synchronous memory port.
//   Assembles them little-endian into a 32-bit instruction and presents it to
//   ID with a valid/ready handshake. Raises stall_req_o so the PC holds while a
//   fetch is in flight or its result has not been consumed.
// PARAMETERS
//   ADDR_W  32  width of pc_i / inst_pc_o (byte address)
//   MEM_AW  17  width of mem_a_o; low MEM_AW bits of the byte address
// PORTS
//   clk           in   1       clock, all state on posedge
//   rst           in   1       synchronous, active-high reset
//   pc_i          in   ADDR_W  address to fetch; upstream holds it while stall_req_o=1
//   ce_i          in   1       1 = pc_i is valid, fetch may start
//   flush_i       in   1       abort in-flight fetch and drop the held instruction
//   mem_busy_i    in   1       1 = memory serving another client; read not accepted
//   mem_din_i     in   8       read data, valid 1 cycle after an accepted read
//   mem_a_o       out  MEM_AW  byte read address (combinational)
//   mem_rd_o      out  1       read strobe (combinational)
//   inst_o        out  32      assembled instruction, byte at pc in [7:0]
//   inst_pc_o     out  ADDR_W  address the instruction was fetched from
//   inst_valid_o  out  1       inst_o/inst_pc_o valid
//   id_ready_i    in   1       ID accepts inst_o this cycle when inst_valid_o=1
//   stall_req_o   out  1       PC must hold (combinational)
// BEHAVIOUR
//   Reset: state=IDLE, inst_o=0, inst_pc_o=0, inst_valid_o=0, counters 0;
//     mem_rd_o=0 and stall_req_o=0 while rst=1. Reset wins over all inputs.
//   States: IDLE, FETCH, OUT. Counters iss_cnt, rcv_cnt are 0..4.
//   Read accept: mem_rd_o=1 and mem_busy_i=0 in cycle t; byte is sampled from
//     mem_din_i at t+1. At most one read is outstanding per cycle.
//   IDLE: if ce_i & !flush_i: latch fetch_pc=pc_i, issue byte 0
//     (mem_a_o=pc_i[MEM_AW-1:0]), go FETCH; iss_cnt=1 only if accepted, else 0.
//   FETCH: issue when iss_cnt<4 & !mem_busy_i at address fetch_pc+iss_cnt.
//     Address sum wraps mod 2^ADDR_W. Misaligned pc is legal, no check.
//     Capture into byte lane rcv_cnt when the previous cycle's read was
//     accepted; then rcv_cnt++. When the 4th byte is captured: inst_o and
//     inst_pc_o are loaded, inst_valid_o=1, go OUT.
//   Latency: no busy, ce_i at cycle t -> inst_valid_o=1 from cycle t+5.
//     Each busy cycle adds exactly one cycle.
//   OUT: hold inst_o, inst_pc_o and inst_valid_o until id_ready_i=1.
//     On handshake: if ce_i & !flush_i, issue byte 0 of pc_i that cycle and
//     go FETCH (back-to-back, no IDLE bubble). Else go IDLE, inst_valid_o=0.
//   stall_req_o = (FETCH) | (OUT & !id_ready_i); 0 in IDLE.
//   flush_i (highest priority after rst), any state: next state IDLE,
//     inst_valid_o=0, counters cleared. No read is issued that cycle.
//     A byte returning the cycle after a flush is ignored.
//   mem_rd_o=0 in IDLE without ce_i, in OUT without handshake, and in FETCH once
//     iss_cnt=4. mem_a_o is don't-care when mem_rd_o=0; drive 0.
// TESTING
//   1 reset: rst=1 two cycles with ce_i=1 -> inst_valid_o=0, mem_rd_o=0,
//     stall_req_o=0, inst_o=0.
//   2 basic: pc_i=0x100, ce_i=1; mem bytes 0x13,0x05,0x10,0x00 at 0x100..0x103
//     -> reads 0x100..0x103 in 4 consecutive cycles; 5 cycles later
//     inst_o=0x00100513, inst_pc_o=0x100, stall_req_o high through FETCH.
//   3 busy: same as 2 with mem_busy_i=1 on the 2nd issue cycle -> address 0x101
//     reissued next cycle, inst_valid_o one cycle later, same inst_o.
//   4 backpressure + back-to-back: id_ready_i=0 for 3 cycles in OUT -> outputs
//     stable, stall_req_o=1; then id_ready_i=1 with pc_i=0x104 -> read 0x104
//     issued that same cycle.
//   5 flush: flush_i=1 after 2 bytes received -> IDLE, inst_valid_o never rises
//     for that pc; the next fetch at pc_i=0x200 completes with correct data.
//   6 wrap: pc_i=0xFFFFFFFE -> addresses 0x1FFFE,0x1FFFF,0x00000,0x00001 on
//     mem_a_o (MEM_AW=17), inst_pc_o=0xFFFFFFFE.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch: reads four bytes over a byte-wide synchronous memory port,
// assembles them little-endian and hands the word to ID with valid/ready.
module if_fetch #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              flush_i,
  input  logic              mem_busy_i,
  input  logic [7:0]        mem_din_i,
  output logic [MEM_AW-1:0] mem_a_o,
  output logic              mem_rd_o,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  input  logic              id_ready_i,
  output logic              stall_req_o
);

  typedef enum logic [1:0] {IDLE, FETCH, OUT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [2:0]          iss_cnt_q, iss_cnt_d;
  logic [2:0]          rcv_cnt_q, rcv_cnt_d;
  logic                pend_q, pend_d;
  logic [23:0]         buf_q, buf_d;
  logic [31:0]         inst_q, inst_d;
  logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   iss_addr;
  logic                start;

  assign iss_addr = fetch_pc_q + ADDR_W'(iss_cnt_q);

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    iss_cnt_d   = iss_cnt_q;
    rcv_cnt_d   = rcv_cnt_q;
    buf_d       = buf_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    valid_d     = valid_q;
    mem_rd_o    = 1'b0;
    mem_a_o     = '0;
    stall_req_o = 1'b0;
    start       = 1'b0;

    if (!rst) begin
      case (state_q)
        IDLE: start = ce_i;
        FETCH: begin
          stall_req_o = 1'b1;
          if (iss_cnt_q < 3'd4) begin
            mem_rd_o = 1'b1;
            mem_a_o  = iss_addr[MEM_AW-1:0];
            if (!mem_busy_i) iss_cnt_d = iss_cnt_q + 3'd1;
          end
        end
        OUT: begin
          if (!id_ready_i) stall_req_o = 1'b1;
          else begin
            valid_d = 1'b0;
            state_d = IDLE;
            start   = ce_i;
          end
        end
        default: state_d = IDLE;
      endcase

      // A byte arrives the cycle after its read was accepted; lanes fill in order.
      if (state_q == FETCH && pend_q) begin
        rcv_cnt_d = rcv_cnt_q + 3'd1;
        case (rcv_cnt_q[1:0])
          2'd0: buf_d[7:0]   = mem_din_i;
          2'd1: buf_d[15:8]  = mem_din_i;
          2'd2: buf_d[23:16] = mem_din_i;
          default: begin
            inst_d    = {mem_din_i, buf_q};
            inst_pc_d = fetch_pc_q;
            valid_d   = 1'b1;
            state_d   = OUT;
          end
        endcase
      end

      // New fetch from IDLE or straight out of an OUT handshake.
      if (start) begin
        mem_rd_o   = 1'b1;
        mem_a_o    = pc_i[MEM_AW-1:0];
        fetch_pc_d = pc_i;
        state_d    = FETCH;
        rcv_cnt_d  = 3'd0;
        iss_cnt_d  = mem_busy_i ? 3'd0 : 3'd1;
      end

      if (flush_i) begin
        mem_rd_o  = 1'b0;
        mem_a_o   = '0;
        state_d   = IDLE;
        valid_d   = 1'b0;
        iss_cnt_d = 3'd0;
        rcv_cnt_d = 3'd0;
      end
    end

    pend_d = mem_rd_o & ~mem_busy_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      iss_cnt_q  <= '0;
      rcv_cnt_q  <= '0;
      pend_q     <= 1'b0;
      buf_q      <= '0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      iss_cnt_q  <= iss_cnt_d;
      rcv_cnt_q  <= rcv_cnt_d;
      pend_q     <= pend_d;
      buf_q      <= buf_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte memory model, busy patterns planned ahead, and a
// transaction-level reference (expected word, latency, accepted address list).
module tb_if_fetch;
  localparam int MEM_AW = 17;
  localparam int MSZ    = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       pc_i;
  logic              ce_i, flush_i, mem_busy_i, id_ready_i;
  logic [7:0]        mem_din_i;
  logic [MEM_AW-1:0] mem_a_o;
  logic              mem_rd_o;
  logic [31:0]       inst_o, inst_pc_o;
  logic              inst_valid_o, stall_req_o;

  if_fetch #(.ADDR_W(32), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .flush_i(flush_i),
    .mem_busy_i(mem_busy_i), .mem_din_i(mem_din_i), .mem_a_o(mem_a_o),
    .mem_rd_o(mem_rd_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_valid_o(inst_valid_o), .id_ready_i(id_ready_i), .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  logic [7:0]        mem [0:MSZ-1];
  logic [MEM_AW-1:0] acc_q[$];
  logic              bp [0:39];
  logic              c0_rd;
  logic [MEM_AW-1:0] c0_a;
  int                n_cmp = 0;
  int                n_err = 0;

  // Memory: accepted read returns data next cycle; otherwise garbage.
  always @(posedge clk) begin
    if (!rst && mem_rd_o && !mem_busy_i) begin
      mem_din_i <= mem[mem_a_o];
      acc_q.push_back(mem_a_o);
    end else
      mem_din_i <= 8'($urandom);
  end

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mem[MEM_AW'(pc + 32'(i))];
    return w;
  endfunction

  // Cycle (relative to issue of byte 0) at which valid is first seen.
  function automatic int exp_lat();
    int n = 0;
    for (int k = 0; k < 40; k++)
      if (!bp[k]) begin
        n++;
        if (n == 4) return k + 2;
      end
    return -2;
  endfunction

  function automatic logic addrs_ok(input logic [31:0] pc);
    if (acc_q.size() != 4) return 1'b0;
    for (int i = 0; i < 4; i++)
      if (acc_q[i] !== MEM_AW'(pc + 32'(i))) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_bp();
    for (int k = 0; k < 40; k++) bp[k] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one fetch (cycle 0 = request cycle) then holds ID off for 'hold' cycles.
  task automatic run_fetch(input logic [31:0] pc, input int hold, output int lat,
                           output logic [31:0] inst, output logic [31:0] ipc, output int bad);
    acc_q.delete();
    bad = 0; lat = -1; inst = 'x; ipc = 'x;
    pc_i = pc; ce_i = 1'b1; id_ready_i = 1'b1; mem_busy_i = bp[0];
    #1 c0_rd = mem_rd_o; c0_a = mem_a_o;
    for (int c = 1; c < 40 && lat < 0; c++) begin
      step();
      id_ready_i = 1'b0;
      mem_busy_i = bp[c];
      if (inst_valid_o) begin
        lat = c; inst = inst_o; ipc = inst_pc_o;
        if (!stall_req_o || mem_rd_o) bad++;
      end else if (!stall_req_o) bad++;
    end
    if (lat >= 0)
      for (int h = 0; h < hold; h++) begin
        step();
        mem_busy_i = 1'($urandom);
        if (!inst_valid_o || inst_o !== inst || inst_pc_o !== ipc || !stall_req_o || mem_rd_o) bad++;
      end
    mem_busy_i = 1'b0;
  endtask

  task automatic drain();
    id_ready_i = 1'b1; ce_i = 1'b0;
    step();
    id_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce_i = 1'b1; pc_i = 32'h40; flush_i = 1'b0; mem_busy_i = 1'b0; id_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if ({inst_valid_o, mem_rd_o, stall_req_o} !== 3'b000 || inst_o !== 32'h0 || inst_pc_o !== 32'h0) begin
        n_err++;
        $display("FAIL reset: vld/rd/stall=%b inst=%h pc=%h, want 000/0/0",
                 {inst_valid_o, mem_rd_o, stall_req_o}, inst_o, inst_pc_o);
      end
    end
    ce_i = 1'b0; rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int lat, bad; logic [31:0] inst, ipc;
    clear_bp();
    run_fetch(32'h100, 0, lat, inst, ipc, bad);
    n_cmp += 4;
    if (lat !== 5) begin n_err++; $display("FAIL basic_lat: got %0d want 5", lat); end
    if (inst !== 32'h00100513 || ipc !== 32'h100) begin
      n_err++; $display("FAIL basic_data: got %h@%h want 00100513@00000100", inst, ipc);
    end
    if (!addrs_ok(32'h100)) begin n_err++; $display("FAIL basic_addr: %0d reads, want 0x100..0x103", acc_q.size()); end
    if (bad !== 0) begin n_err++; $display("FAIL basic_stall: %0d bad cycles want 0", bad); end
    drain();
    n_cmp++;
    if (inst_valid_o !== 1'b0 || stall_req_o !== 1'b0) begin
      n_err++; $display("FAIL basic_drain: vld=%b stall=%b want 0 0", inst_valid_o, stall_req_o);
    end
  endtask

  task automatic test_busy();
    int lat, bad; logic [31:0] inst, ipc;
    clear_bp(); bp[1] = 1'b1;
    run_fetch(32'h100, 0, lat, inst, ipc, bad);
    n_cmp += 3;
    if (lat !== 6) begin n_err++; $display("FAIL busy_lat: got %0d want 6", lat); end
    if (inst !== 32'h00100513) begin n_err++; $display("FAIL busy_data: got %h want 00100513", inst); end
    if (!addrs_ok(32'h100) || bad !== 0) begin
      n_err++; $display("FAIL busy_addr: reads=%0d bad=%0d want 4 0", acc_q.size(), bad);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int lat, bad; logic [31:0] inst, ipc;
    clear_bp();
    run_fetch(32'h100, 3, lat, inst, ipc, bad);
    n_cmp++;
    if (bad !== 0 || inst !== 32'h00100513) begin
      n_err++; $display("FAIL backpressure: bad=%0d inst=%h want 0 00100513", bad, inst);
    end
    run_fetch(32'h104, 0, lat, inst, ipc, bad);
    n_cmp += 2;
    if (c0_rd !== 1'b1 || c0_a !== 17'h104) begin
      n_err++; $display("FAIL b2b_issue: rd=%b a=%h want 1 00104", c0_rd, c0_a);
    end
    if (lat !== 5 || inst !== exp_inst(32'h104) || ipc !== 32'h104 || bad !== 0) begin
      n_err++; $display("FAIL b2b_data: lat=%0d inst=%h pc=%h bad=%0d want 5 %h 104 0",
                        lat, inst, ipc, bad, exp_inst(32'h104));
    end
    drain();
  endtask

  task automatic test_flush();
    int lat, bad, seen; logic [31:0] inst, ipc;
    clear_bp();
    acc_q.delete();
    pc_i = 32'h300; ce_i = 1'b1; id_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    flush_i = 1'b1;
    #1 n_cmp++;
    if (mem_rd_o !== 1'b0) begin n_err++; $display("FAIL flush_rd: got %b want 0", mem_rd_o); end
    step();
    flush_i = 1'b0; ce_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (inst_valid_o || stall_req_o || mem_rd_o) seen++;
      step();
    end
    n_cmp += 2;
    if (seen !== 0) begin n_err++; $display("FAIL flush_idle: %0d active cycles want 0", seen); end
    if (acc_q.size() !== 3) begin n_err++; $display("FAIL flush_reads: got %0d want 3", acc_q.size()); end
    run_fetch(32'h200, 0, lat, inst, ipc, bad);
    n_cmp++;
    if (lat !== 5 || inst !== exp_inst(32'h200) || ipc !== 32'h200 || bad !== 0) begin
      n_err++; $display("FAIL flush_next: lat=%0d inst=%h pc=%h bad=%0d want 5 %h 200 0",
                        lat, inst, ipc, bad, exp_inst(32'h200));
    end
    drain();
  endtask

  task automatic test_wrap();
    int lat, bad; logic [31:0] inst, ipc;
    clear_bp();
    run_fetch(32'hFFFF_FFFE, 0, lat, inst, ipc, bad);
    n_cmp += 2;
    if (acc_q.size() !== 4 || acc_q[0] !== 17'h1FFFE || acc_q[1] !== 17'h1FFFF ||
        acc_q[2] !== 17'h0 || acc_q[3] !== 17'h1) begin
      n_err++; $display("FAIL wrap_addr: %0d reads, want 1fffe 1ffff 0 1", acc_q.size());
    end
    if (ipc !== 32'hFFFF_FFFE || inst !== {mem[1], mem[0], mem[17'h1FFFF], mem[17'h1FFFE]} || lat !== 5) begin
      n_err++; $display("FAIL wrap_data: inst=%h pc=%h lat=%0d", inst, ipc, lat);
    end
    drain();
  endtask

  task automatic test_random();
    int lat, bad, chained; logic [31:0] inst, ipc, pc;
    chained = 0;
    for (int it = 0; it < 12; it++) begin
      pc = $urandom;
      for (int k = 0; k < 40; k++) bp[k] = (k < 12) && ($urandom_range(0, 9) < 3);
      run_fetch(pc, $urandom_range(0, 3), lat, inst, ipc, bad);
      n_cmp++;
      if (lat !== exp_lat() || inst !== exp_inst(pc) || ipc !== pc || bad !== 0 || !addrs_ok(pc)) begin
        n_err++; $display("FAIL rand%0d: lat=%0d/%0d inst=%h/%h pc=%h bad=%0d reads=%0d",
                          it, lat, exp_lat(), inst, exp_inst(pc), ipc, bad, acc_q.size());
      end
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < MSZ; i++) mem[i] = 8'($urandom);
    mem[17'h100] = 8'h13; mem[17'h101] = 8'h05; mem[17'h102] = 8'h10; mem[17'h103] = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_busy();
    test_back_to_back();
    test_flush();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
